// File: rtl/stream_window_buffer.sv
// Circular sample buffer that turns a valid/ready sample stream into registered
// N-tap sliding windows (oldest tap at the low bits), one window every STRIDE samples.
module stream_window_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 24,
    parameter int N      = 8,
    parameter int STRIDE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N*DATA_W-1:0]       out_window,
    output logic [$clog2(N+1)-1:0]    fill_level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(N + 1);
    localparam int SC_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(N - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(STRIDE - 1);

    if (DEPTH < N || N < 2 || STRIDE < 1 || STRIDE > N) begin : g_param_err
        $error("stream_window_buffer: need N >= 2, DEPTH >= N and 1 <= STRIDE <= N");
    end

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [SC_W-1:0]     stride_cnt_q, stride_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [N*DATA_W-1:0] window_q, window_d;
    logic [N*DATA_W-1:0] taps_s;
    logic                accept_s;
    logic                emit_s;

    // Modular subtraction that works for any DEPTH, not just powers of two.
    function automatic logic [PTR_W-1:0] tap_addr(input logic [PTR_W-1:0] ptr,
                                                  input int unsigned      back);
        logic [PTR_W:0] p;
        logic [PTR_W:0] b;
        p = {1'b0, ptr};
        b = (PTR_W + 1)'(back);
        if (p >= b) begin
            return PTR_W'(p - b);
        end else begin
            return PTR_W'(p + (PTR_W + 1)'(DEPTH) - b);
        end
    endfunction

    assign in_ready   = !out_valid_q || out_ready;
    assign accept_s   = in_valid && in_ready && !clear;
    assign out_valid  = out_valid_q;
    assign out_window = window_q;
    assign fill_level = count_q;

    // Gather the N-1 older samples from memory; the newest tap bypasses from in_data.
    always_comb begin
        taps_s = '0;
        for (int i = 0; i < N - 1; i++) begin
            taps_s[i*DATA_W +: DATA_W] = mem_q[tap_addr(wr_ptr_q, N - 1 - i)];
        end
        taps_s[(N-1)*DATA_W +: DATA_W] = in_data;
    end

    // Next-state logic for pointer, fill count, stride counter and output window.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        stride_cnt_d = stride_cnt_q;
        out_valid_d  = out_valid_q;
        window_d     = window_q;
        emit_s       = 1'b0;

        if (clear) begin
            wr_ptr_d     = '0;
            count_d      = '0;
            stride_cnt_d = '0;
            out_valid_d  = 1'b0;
        end else begin
            if (accept_s) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
                if (count_q != CNT_FULL) begin
                    count_d = count_q + 1'b1;
                end else begin
                    count_d = count_q;
                end
                if (count_q == CNT_PRE) begin
                    emit_s = 1'b1;
                end else if (count_q == CNT_FULL && stride_cnt_q == SC_LAST) begin
                    emit_s = 1'b1;
                end else begin
                    emit_s = 1'b0;
                end
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (emit_s) begin
                stride_cnt_d = '0;
            end else if (accept_s && count_q == CNT_FULL) begin
                stride_cnt_d = stride_cnt_q + 1'b1;
            end else begin
                stride_cnt_d = stride_cnt_q;
            end

            // A window loading in the same cycle as a handoff keeps out_valid high.
            if (emit_s) begin
                out_valid_d = 1'b1;
                window_d    = taps_s;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            count_q      <= '0;
            stride_cnt_q <= '0;
            out_valid_q  <= 1'b0;
            window_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            stride_cnt_q <= stride_cnt_d;
            out_valid_q  <= out_valid_d;
            window_q     <= window_d;
        end
    end

    // Sample storage; contents survive reset and clear.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_stream_window_buffer.sv
// Directed bench for stream_window_buffer: N=3, DEPTH=4 at STRIDE=1 and STRIDE=2.
module tb_stream_window_buffer;

    localparam int DW = 8;
    localparam int NT = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [NT*DW-1:0] out_window;
    logic [1:0]    fill_level;

    logic          clear2, in_valid2, out_ready2;
    logic [DW-1:0] in_data2;
    logic          in_ready2, out_valid2;
    logic [NT*DW-1:0] out_window2;
    logic [1:0]    fill_level2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stream_window_buffer #(.DATA_W(DW), .DEPTH(4), .N(NT), .STRIDE(1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_window(out_window), .fill_level(fill_level)
    );

    stream_window_buffer #(.DATA_W(DW), .DEPTH(4), .N(NT), .STRIDE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_window(out_window2), .fill_level(fill_level2)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NT*DW-1:0] win3(input int a, input int b, input int c);
        return {DW'(c), DW'(b), DW'(a)};
    endfunction

    // Present one sample (or idle) to dut at a negedge, return at the next negedge.
    task automatic step(input logic v, input int d);
        in_valid = v;
        in_data  = DW'(d);
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        clear2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_window", out_window, 0);
        check_eq("rst_fill", fill_level, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Stream 1..10: wr_ptr wraps twice, every window must stay in arrival order.
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, k);
            check_eq($sformatf("s1_fill_%0d", k), fill_level, (k >= 3) ? 3 : k);
            check_eq($sformatf("s1_valid_%0d", k), out_valid, (k >= 3) ? 1 : 0);
            if (k >= 3) check_eq($sformatf("s1_win_%0d", k), out_window, win3(k - 2, k - 1, k));
        end
        step(1'b0, 0);
        check_eq("s1_drain_valid", out_valid, 0);
        check_eq("s1_drain_win", out_window, win3(8, 9, 10));

        // STRIDE=2: windows only after samples 3, 5 and 7.
        for (int k = 1; k <= 7; k++) begin
            in_valid2 = 1'b1;
            in_data2  = DW'(k);
            @(negedge clk);
            check_eq($sformatf("s2_valid_%0d", k), out_valid2, (k == 3 || k == 5 || k == 7) ? 1 : 0);
            if (k == 3 || k == 5 || k == 7)
                check_eq($sformatf("s2_win_%0d", k), out_window2, win3(k - 2, k - 1, k));
        end
        in_valid2 = 1'b0;

        // Backpressure: window (1,2,3) held, sample 4 not consumed.
        do_clear();
        check_eq("bp_clear_fill", fill_level, 0);
        check_eq("bp_clear_valid", out_valid, 0);
        for (int k = 1; k <= 3; k++) step(1'b1, k);
        check_eq("bp_first_win", out_window, win3(1, 2, 3));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(4);
        #1;
        check_eq("bp_in_ready_low", in_ready, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq($sformatf("bp_hold_valid_%0d", c), out_valid, 1);
            check_eq($sformatf("bp_hold_win_%0d", c), out_window, win3(1, 2, 3));
            check_eq($sformatf("bp_hold_rdy_%0d", c), in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_in_ready_high", in_ready, 1);
        @(negedge clk);
        check_eq("bp_next_valid", out_valid, 1);
        check_eq("bp_next_win", out_window, win3(2, 3, 4));
        step(1'b0, 0);
        check_eq("bp_drain_valid", out_valid, 0);

        // Clear with a sample in the same cycle drops that sample.
        do_clear();
        for (int k = 1; k <= 3; k++) step(1'b1, k);
        check_eq("clr_pre_win", out_window, win3(1, 2, 3));
        clear = 1'b1; in_valid = 1'b1; in_data = DW'(9);
        @(negedge clk);
        clear = 1'b0;
        check_eq("clr_valid", out_valid, 0);
        check_eq("clr_fill", fill_level, 0);
        check_eq("clr_win_hold", out_window, win3(1, 2, 3));
        step(1'b1, 10);
        check_eq("clr_fill_10", fill_level, 1);
        check_eq("clr_valid_10", out_valid, 0);
        step(1'b1, 11);
        check_eq("clr_valid_11", out_valid, 0);
        step(1'b1, 12);
        check_eq("clr_valid_12", out_valid, 1);
        check_eq("clr_win_12", out_window, win3(10, 11, 12));

        // Asynchronous reset mid-cycle after two samples.
        do_clear();
        step(1'b1, 1);
        step(1'b1, 2);
        check_eq("ar_fill_pre", fill_level, 2);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_fill", fill_level, 0);
        check_eq("ar_valid", out_valid, 0);
        check_eq("ar_window", out_window, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 5);
        check_eq("ar_valid_5", out_valid, 0);
        step(1'b1, 6);
        check_eq("ar_valid_6", out_valid, 0);
        step(1'b1, 7);
        check_eq("ar_valid_7", out_valid, 1);
        check_eq("ar_win_7", out_window, win3(5, 6, 7));
        step(1'b0, 0);
        check_eq("ar_drain_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
